// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle barrel replacement. Takes an operand, a shift
// amount and a mode over valid/ready. Shifts by at most STEP bits per clock,
// then holds the result until the consumer takes it.
module iterative_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  localparam logic [SHW-1:0] STEP_C  = SHW'(STEP);
  localparam logic [SHW:0]   WIDTH_C = (SHW+1)'(WIDTH);

  state_e           state_q, state_d;
  mode_e            mode_q,  mode_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0]   rem_q,   rem_d;

  logic [SHW-1:0]   step_amt;
  logic [SHW:0]     rot_back;
  logic [WIDTH-1:0] shifted;

  // Handshake and status outputs decode straight from the state register.
  assign in_ready  = (state_q == IDLE) && !clear;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;

  // Next-state and datapath: one bounded shift step per SHIFT cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    data_d   = data_q;
    rem_d    = rem_q;

    step_amt = (rem_q < STEP_C) ? rem_q : STEP_C;
    // Left-shift distance that brings the bits leaving the LSB back in at the MSB.
    rot_back = WIDTH_C - {1'b0, step_amt};

    unique case (mode_q)
      MODE_LSL: shifted = data_q << step_amt;
      MODE_LSR: shifted = data_q >> step_amt;
      MODE_ASR: shifted = WIDTH'($signed(data_q) >>> step_amt);
      MODE_ROR: shifted = (data_q >> step_amt) | (data_q << rot_back);
      default:  shifted = data_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          rem_d   = in_amt;
          mode_d  = mode_e'(in_mode);
          state_d = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition above; the partial result is dropped.
    if (clear) begin
      state_d = IDLE;
      rem_d   = '0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_LSL;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter (WIDTH=32, STEP=4). Expected results
// are queued at accept time and compared when the DUT hands a result over.
module tb_iterative_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;
  localparam int SHW   = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [SHW-1:0]   in_amt = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int last_hs  = -1;
  logic [WIDTH-1:0] exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: apply the operation one bit at a time.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int amt,
                                             input logic [1:0] m);
    for (int i = 0; i < amt; i++) begin
      case (m)
        2'b00:   d = {d[WIDTH-2:0], 1'b0};
        2'b01:   d = {1'b0, d[WIDTH-1:1]};
        2'b10:   d = {d[WIDTH-1], d[WIDTH-1:1]};
        default: d = {d[0], d[WIDTH-1:1]};
      endcase
    end
    return d;
  endfunction

  // Result monitor: a transfer happens on the edge following a negedge where
  // both out_valid and out_ready are high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      last_hs = cycle + 1;
      if (exp_q.size() == 0) check("unexpected_result", out_data, 64'hDEAD_0000_DEAD);
      else                   check("result", out_data, exp_q.pop_front());
    end
  end

  // Drive one request, wait (bounded) for acceptance; returns #1 after the accept edge.
  task automatic send(input logic [WIDTH-1:0] d, input int amt, input logic [1:0] m,
                      input logic [WIDTH-1:0] exp, output int acc_cycle);
    int waited = 0;
    acc_cycle = -1;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt[SHW-1:0];
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    acc_cycle = cycle;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = SHW'($urandom);
    in_mode  = 2'($urandom);
  endtask

  // Full transaction with out_ready high: checks latency, busy length, in_ready after.
  task automatic run_one(input logic [WIDTH-1:0] d, input int amt, input logic [1:0] m,
                         input logic [WIDTH-1:0] exp);
    int acc, n, lat, nb, steps;
    send(d, amt, m, exp, acc);
    steps = (amt + STEP - 1) / STEP;
    n = 0; lat = -1; nb = 0;
    while (busy && n < 200) begin
      if (out_valid && lat < 0) lat = n;
      nb++;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", lat, steps);
    check("busy_cycles", nb, steps + 1);
    check("in_ready_after", in_ready, 1);
  endtask

  initial begin
    int acc1, acc2;
    bit seen_valid;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed functional cases
    run_one(32'h0000_0001, 4, 2'b00, 32'h0000_0010);
    run_one(32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
    run_one(32'h8000_0000, 31, 2'b01, 32'h0000_0001);
    run_one(32'h1234_5678, 10, 2'b11, 32'h9E04_8D15);
    run_one(32'h8765_4321, 5, 2'b10, 32'hFC3B_2A19);
    run_one(32'hA5A5_A5A5, 1, 2'b00, 32'h4B4B_4B4A);

    // amt=0 with a stalled consumer
    out_ready = 1'b0;
    send(32'hDEAD_BEEF, 0, 2'b01, 32'hDEAD_BEEF, acc1);
    check("amt0_valid_next", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_data", out_data, 32'hDEAD_BEEF);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("stall_queue_drained", exp_q.size(), 0);

    // Back-to-back requests
    send(32'h0000_00F0, 8, 2'b00, 32'h0000_F000, acc1);
    send(32'hF000_0000, 3, 2'b10, 32'hFE00_0000, acc2);
    check("b2b_accept_cycle", acc2, last_hs + 1);
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("b2b_queue_drained", exp_q.size(), 0);

    // Clear mid-SHIFT
    send(32'h0000_0003, 20, 2'b00, 32'h0030_0000, acc1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clear = 1'b1;
    #1;
    check("clear_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    void'(exp_q.pop_back());
    check("clear_busy", busy, 0);
    check("clear_out_valid", out_valid, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("clear_no_result", seen_valid, 0);

    // Async reset mid-SHIFT
    send(32'h0000_0003, 20, 2'b00, 32'h0030_0000, acc1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_no_pulse", out_valid, 0);
    run_one(32'hCAFE_F00D, 13, 2'b11, 32'h806E_57F7);

    // Random operations against the bit-serial model
    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] d;
      int a;
      logic [1:0] m;
      d = $urandom;
      a = $urandom_range(0, WIDTH - 1);
      m = 2'($urandom_range(0, 3));
      run_one(d, a, m, model(d, a, m));
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
